// File: rtl/vec_ctrl_pkg.sv
// vec_ctrl_pkg: shared lane geometry, sequencer state encoding and B-source select codes.
//   LANES  - ALU lanes per chunk
//   MAXVL  - largest legal vector length in elements
//   state_t - sequencer FSM states
//   VSI_*  - OpVSIFlag encodings (3 is illegal)
package vec_ctrl_pkg;
    localparam int LANES = 6;
    localparam int MAXVL = 48;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam logic [1:0] VSI_VEC = 2'd0;
    localparam logic [1:0] VSI_SCL = 2'd1;
    localparam logic [1:0] VSI_IMM = 2'd2;
endpackage

// File: rtl/lane_mask_gen.sv
// lane_mask_gen: remaining element count -> low-justified active-lane mask.
//   rem  in  RW     elements still to process from this chunk onward
//   mask out LANES  bit i set when lane i holds a live element
module lane_mask_gen #(
    parameter int LANES = 6,
    parameter int RW    = 7
) (
    input  logic [RW-1:0]    rem,
    output logic [LANES-1:0] mask
);
    for (genvar i = 0; i < LANES; i++) begin : g_bit
        assign mask[i] = rem > RW'(i);
    end
endmodule

// File: rtl/alu_lane_sequencer.sv
// alu_lane_sequencer: splits a vector ALU op into LANES-wide chunks and tracks writeback.
//   clk, reset                        clock, synchronous active-high reset
//   StartD, Op*                       request and its fields, taken when BusyS=0
//   StallE, ALUFlagsE                 downstream stall, lane-0 flags
//   BusyS, ErrS                       op in progress, one-cycle reject pulse
//   ALUControlE..ImmE, IssueE,
//   ChunkE, LaneMaskE                 current chunk issue to the lane ALUs
//   WriteEnW, WriteChunkW, WriteMaskW writeback of the issue consumed last cycle
//   FlagsW, DoneW                     final-chunk flags, completion pulse
module alu_lane_sequencer #(
    parameter int N     = 8,
    parameter int LANES = vec_ctrl_pkg::LANES,
    parameter int MAXVL = vec_ctrl_pkg::MAXVL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartD,
    input  logic [2:0]       OpALUControl,
    input  logic [1:0]       OpVSIFlag,
    input  logic [3:0]       OpSrcBi,
    input  logic [N-1:0]     OpImm,
    input  logic [5:0]       OpVL,
    input  logic             StallE,
    input  logic [1:0]       ALUFlagsE,
    output logic             BusyS,
    output logic             ErrS,
    output logic [2:0]       ALUControlE,
    output logic [1:0]       VSIFlagE,
    output logic [3:0]       SrcBiE,
    output logic [N-1:0]     ImmE,
    output logic             IssueE,
    output logic [2:0]       ChunkE,
    output logic [LANES-1:0] LaneMaskE,
    output logic             WriteEnW,
    output logic [2:0]       WriteChunkW,
    output logic [LANES-1:0] WriteMaskW,
    output logic [1:0]       FlagsW,
    output logic             DoneW
);
    import vec_ctrl_pkg::*;

    state_t           state_q, state_d;
    logic [2:0]       alu_q, alu_d, chunk_q, chunk_d, wchunk_q, wchunk_d;
    logic [1:0]       vsi_q, vsi_d, flags_q, flags_d;
    logic [3:0]       srcbi_q, srcbi_d;
    logic [N-1:0]     imm_q, imm_d;
    logic [5:0]       vl_q, vl_d;
    logic [LANES-1:0] wmask_q, wmask_d, mask;
    logic             wen_q, wen_d, err_q, err_d;
    logic [6:0]       rem;
    logic             busy, illegal, accept, consume, last;

    // Elements left from the current chunk onward; the final chunk is the one with rem <= LANES.
    assign rem     = {1'b0, vl_q} - 7'(LANES * int'(chunk_q));
    assign last    = rem <= 7'(LANES);
    assign busy    = state_q == ISSUE;
    assign consume = busy && !StallE;
    assign illegal = (int'(OpVL) > MAXVL) || (OpVSIFlag == 2'd3) ||
                     (OpVSIFlag == VSI_SCL && int'(OpSrcBi) >= LANES);
    assign accept  = StartD && !busy && !illegal;

    lane_mask_gen #(.LANES(LANES), .RW(7)) u_mask (.rem(rem), .mask(mask));

    always_comb begin
        state_d  = state_q;
        alu_d    = alu_q;
        vsi_d    = vsi_q;
        srcbi_d  = srcbi_q;
        imm_d    = imm_q;
        vl_d     = vl_q;
        chunk_d  = chunk_q;
        flags_d  = (consume && last) ? ALUFlagsE : flags_q;
        wen_d    = consume;
        wchunk_d = consume ? chunk_q : '0;
        wmask_d  = consume ? mask : '0;
        err_d    = StartD && !busy && illegal;
        if (accept) begin
            alu_d   = OpALUControl;
            vsi_d   = OpVSIFlag;
            srcbi_d = OpSrcBi;
            imm_d   = OpImm;
            vl_d    = OpVL;
            chunk_d = '0;
            flags_d = '0;
            state_d = (OpVL == '0) ? DRAIN : ISSUE;
        end else if (busy) begin
            chunk_d = consume ? chunk_q + 3'd1 : chunk_q;
            state_d = (consume && last) ? DRAIN : ISSUE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            alu_q    <= '0;
            vsi_q    <= '0;
            srcbi_q  <= '0;
            imm_q    <= '0;
            vl_q     <= '0;
            chunk_q  <= '0;
            flags_q  <= '0;
            wen_q    <= 1'b0;
            wchunk_q <= '0;
            wmask_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            alu_q    <= alu_d;
            vsi_q    <= vsi_d;
            srcbi_q  <= srcbi_d;
            imm_q    <= imm_d;
            vl_q     <= vl_d;
            chunk_q  <= chunk_d;
            flags_q  <= flags_d;
            wen_q    <= wen_d;
            wchunk_q <= wchunk_d;
            wmask_q  <= wmask_d;
            err_q    <= err_d;
        end
    end

    // Issue-side controls are only meaningful while issuing; forced to zero otherwise.
    assign BusyS       = busy;
    assign ErrS        = err_q;
    assign IssueE      = busy;
    assign ALUControlE = busy ? alu_q : '0;
    assign VSIFlagE    = busy ? vsi_q : '0;
    assign SrcBiE      = busy ? srcbi_q : '0;
    assign ImmE        = busy ? imm_q : '0;
    assign ChunkE      = busy ? chunk_q : '0;
    assign LaneMaskE   = busy ? mask : '0;
    assign WriteEnW    = wen_q;
    assign WriteChunkW = wchunk_q;
    assign WriteMaskW  = wmask_q;
    assign FlagsW      = flags_q;
    assign DoneW       = state_q == DRAIN;
endmodule

// File: tb/tb_alu_lane_sequencer.sv
// tb_alu_lane_sequencer: scoreboard bench with directed scenarios and randomized ops.
module tb_alu_lane_sequencer;
    localparam int N = 8;
    localparam int L = 6;
    localparam int MAXVL = 48;

    logic clk = 1'b0;
    logic reset, StartD, StallE;
    logic [2:0] OpALUControl;
    logic [1:0] OpVSIFlag, ALUFlagsE;
    logic [3:0] OpSrcBi;
    logic [N-1:0] OpImm;
    logic [5:0] OpVL;
    logic BusyS, ErrS, IssueE, WriteEnW, DoneW;
    logic [2:0] ALUControlE, ChunkE, WriteChunkW;
    logic [1:0] VSIFlagE, FlagsW;
    logic [3:0] SrcBiE;
    logic [N-1:0] ImmE;
    logic [L-1:0] LaneMaskE, WriteMaskW;

    alu_lane_sequencer #(.N(N), .LANES(L), .MAXVL(MAXVL)) dut (
        .clk(clk), .reset(reset), .StartD(StartD), .OpALUControl(OpALUControl),
        .OpVSIFlag(OpVSIFlag), .OpSrcBi(OpSrcBi), .OpImm(OpImm), .OpVL(OpVL),
        .StallE(StallE), .ALUFlagsE(ALUFlagsE), .BusyS(BusyS), .ErrS(ErrS),
        .ALUControlE(ALUControlE), .VSIFlagE(VSIFlagE), .SrcBiE(SrcBiE), .ImmE(ImmE),
        .IssueE(IssueE), .ChunkE(ChunkE), .LaneMaskE(LaneMaskE), .WriteEnW(WriteEnW),
        .WriteChunkW(WriteChunkW), .WriteMaskW(WriteMaskW), .FlagsW(FlagsW), .DoneW(DoneW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   chunk;
        logic [L-1:0] mask;
        logic [2:0]   alu;
        logic [1:0]   vsi;
        logic [3:0]   srcbi;
        logic [N-1:0] imm;
        bit           last;
    } iss_t;

    iss_t iss_q[$];
    iss_t wr_q[$];
    int   done_q[$];
    int   err_pend = 0;
    int   checks = 0;
    int   passes = 0;
    bit   rnd_stall = 0;
    logic [1:0] last_flags = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [L-1:0] model_mask(input int vl, input int k);
        int cnt = (vl + L - 1) / L;
        int n = (k < cnt - 1) ? L : vl - L * (cnt - 1);
        logic [L-1:0] m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic bit legal(input int vsi, input int srcbi, input int vl);
        return vl <= MAXVL && vsi != 3 && !(vsi == 1 && srcbi >= L);
    endfunction

    task automatic expect_op(input logic [2:0] alu, input logic [1:0] vsi, input logic [3:0] srcbi,
                             input logic [N-1:0] imm, input int vl);
        int cnt;
        if (!legal(vsi, srcbi, vl)) begin
            err_pend++;
            return;
        end
        cnt = (vl + L - 1) / L;
        for (int k = 0; k < cnt; k++)
            iss_q.push_back('{chunk: 3'(k), mask: model_mask(vl, k), alu: alu, vsi: vsi,
                              srcbi: srcbi, imm: imm, last: (k == cnt - 1)});
        done_q.push_back(vl);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic start(input logic [2:0] alu, input logic [1:0] vsi, input logic [3:0] srcbi,
                         input logic [N-1:0] imm, input int vl);
        OpALUControl = alu;
        OpVSIFlag = vsi;
        OpSrcBi = srcbi;
        OpImm = imm;
        OpVL = 6'(vl);
        StartD = 1'b1;
        expect_op(alu, vsi, srcbi, imm, vl);
        step();
        StartD = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BusyS !== 1'b0 && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) chk("idle_timeout", BusyS, 0);
    endtask

    // Flags and stall driver; stall is only randomized in the random phase.
    initial begin
        ALUFlagsE = '0;
        forever begin
            @(posedge clk);
            #1;
            ALUFlagsE = 2'($urandom);
            if (rnd_stall) StallE = ($urandom % 4 == 0);
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT presents an event.
    always @(negedge clk) begin
        iss_t e;
        int vl;
        if (reset === 1'b0) begin
            if (IssueE && !StallE) begin
                if (iss_q.size() == 0) chk("issue_spurious", IssueE, 0);
                else begin
                    e = iss_q.pop_front();
                    chk("issue_chunk", ChunkE, e.chunk);
                    chk("issue_mask", LaneMaskE, e.mask);
                    chk("issue_ctrl", {ALUControlE, VSIFlagE, SrcBiE, ImmE},
                        {e.alu, e.vsi, e.srcbi, e.imm});
                    wr_q.push_back(e);
                    if (e.last) last_flags = ALUFlagsE;
                end
            end
            if (WriteEnW) begin
                if (wr_q.size() == 0) chk("wr_spurious", WriteEnW, 0);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_chunk", WriteChunkW, e.chunk);
                    chk("wr_mask", WriteMaskW, e.mask);
                end
            end
            if (DoneW) begin
                if (done_q.size() == 0) chk("done_spurious", DoneW, 0);
                else begin
                    vl = done_q.pop_front();
                    chk("done_wen", WriteEnW, vl > 0);
                    chk("done_busy", BusyS, 0);
                    if (vl > 0) chk("done_flags", FlagsW, last_flags);
                end
            end
            if (ErrS) begin
                chk("err_expected", err_pend > 0, 1);
                if (err_pend > 0) err_pend--;
            end
            if (!BusyS) chk("issue_outside", IssueE, 0);
            if (!BusyS && !DoneW)
                chk("idle_ctrl_zero", {ALUControlE, VSIFlagE, SrcBiE, ImmE, ChunkE, LaneMaskE}, 0);
        end
    end

    function automatic logic [63:0] all_outs();
        return {BusyS, ErrS, ALUControlE, VSIFlagE, SrcBiE, ImmE, IssueE, ChunkE, LaneMaskE,
                WriteEnW, WriteChunkW, WriteMaskW, FlagsW, DoneW};
    endfunction

    initial begin
        int wen_cnt;
        reset = 1'b1;
        StartD = 1'b0;
        StallE = 1'b0;
        OpALUControl = '0;
        OpVSIFlag = '0;
        OpSrcBi = '0;
        OpImm = '0;
        OpVL = '0;
        step();
        step();
        samp();
        chk("reset_outputs", all_outs(), 0);
        step();
        reset = 1'b0;
        step();

        // 13 elements, vector B: three chunks, last has one lane
        start(3'd2, 2'd0, 4'd0, 8'h5A, 13);
        for (int k = 0; k < 3; k++) begin
            samp();
            chk("v13_issue", {IssueE, ChunkE}, {1'b1, 3'(k)});
            chk("v13_mask", LaneMaskE, (k == 2) ? 6'b000001 : 6'b111111);
            step();
        end
        samp();
        chk("v13_done", {DoneW, WriteEnW, WriteMaskW, BusyS}, {1'b1, 1'b1, 6'b000001, 1'b0});
        step();
        wait_idle();

        // 12 elements with a two-cycle stall on chunk 1
        start(3'd5, 2'd2, 4'd0, 8'hC3, 12);
        wen_cnt = 0;
        samp();
        chk("v12_chunk0", ChunkE, 0);
        wen_cnt += int'(WriteEnW);
        step();
        for (int c = 2; c <= 5; c++) begin
            if (c == 2) StallE = 1'b1;
            if (c == 4) StallE = 1'b0;
            samp();
            if (c <= 4) chk("v12_hold", {IssueE, ChunkE}, {1'b1, 3'd1});
            if (c == 5) chk("v12_done", DoneW, 1);
            wen_cnt += int'(WriteEnW);
            step();
        end
        chk("v12_wen_count", wen_cnt, 2);
        wait_idle();

        // scalar lane index bounds
        start(3'd1, 2'd1, 4'd6, 8'h11, 10);
        samp();
        chk("srcbi6_err", {ErrS, BusyS}, 2'b10);
        step();
        start(3'd1, 2'd1, 4'd5, 8'h11, 10);
        samp();
        chk("srcbi5_issue", {IssueE, SrcBiE, VSIFlagE}, {1'b1, 4'd5, 2'd1});
        step();
        wait_idle();

        // zero length and over-length
        start(3'd3, 2'd0, 4'd0, 8'h00, 0);
        samp();
        chk("vl0_done", {DoneW, IssueE, WriteEnW}, 3'b100);
        step();
        start(3'd3, 2'd0, 4'd0, 8'h00, 49);
        samp();
        chk("vl49_err", {ErrS, BusyS}, 2'b10);
        step();
        wait_idle();

        // back-to-back: StartD held with 6 elements
        OpALUControl = 3'd4;
        OpVSIFlag = 2'd0;
        OpSrcBi = 4'd0;
        OpImm = 8'h77;
        OpVL = 6'd6;
        StartD = 1'b1;
        expect_op(3'd4, 2'd0, 4'd0, 8'h77, 6);
        step();
        samp();
        chk("b2b_busy", BusyS, 1);
        step();
        samp();
        chk("b2b_done1", {DoneW, BusyS, ErrS}, 3'b100);
        expect_op(3'd4, 2'd0, 4'd0, 8'h77, 6);
        step();
        StartD = 1'b0;
        samp();
        chk("b2b_issue2", IssueE, 1);
        step();
        samp();
        chk("b2b_done2", DoneW, 1);
        step();
        wait_idle();

        // randomized ops with random stalls
        rnd_stall = 1;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) step();
            wait_idle();
            start(3'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom % 8 == 0) ? int'($urandom_range(49, 63)) : int'($urandom_range(0, 48)));
        end
        wait_idle();
        rnd_stall = 0;
        StallE = 1'b0;
        repeat (3) step();

        // reset in the middle of a 48-element op
        start(3'd6, 2'd0, 4'd0, 8'h3C, 48);
        step();
        step();
        step();
        samp();
        chk("mid_chunk3", ChunkE, 3);
        step();
        reset = 1'b1;
        iss_q.delete();
        wr_q.delete();
        done_q.delete();
        err_pend = 0;
        step();
        reset = 1'b0;
        samp();
        chk("mid_reset_zero", all_outs(), 0);
        step();
        repeat (3) step();
        start(3'd7, 2'd2, 4'd0, 8'h99, 6);
        wait_idle();
        repeat (4) step();

        chk("iss_left", iss_q.size(), 0);
        chk("wr_left", wr_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        chk("err_left", err_pend, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_lane_sequencer.md
ALU_LANE_SEQUENCER -- requirements
Module: alu_lane_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning element width in bits.
REQ-002 The block SHALL have parameter LANES, default 6, meaning ALU lanes per chunk.
REQ-003 The block SHALL have parameter MAXVL, default 48, meaning maximum vector length (8 chunks).
REQ-004 Port clk  in  1  sole clock, rising edge; one clock; reset is synchronous and active-high.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port StartD  in  1  operation request, sampled when BusyS=0.
REQ-007 Port OpALUControl  in  3  ALU operation code, latched on accept.
REQ-008 Port OpVSIFlag  in  2  B-source select: 0 vector, 1 scalar lane, 2 immediate; 3 illegal.
REQ-009 Port OpSrcBi  in  4  scalar lane index for OpVSIFlag=1.
REQ-010 Port OpImm  in  N  immediate operand.
REQ-011 Port OpVL  in  6  vector length in elements.
REQ-012 Port StallE  in  1  downstream stall; current issue not consumed.
REQ-013 Port ALUFlagsE  in  2  lane-0 flags from the lane ALU.
REQ-014 Port BusyS  out  1  operation in progress; requests ignored.
REQ-015 Port ErrS  out  1  one-cycle pulse: request rejected.
REQ-016 Ports ALUControlE out 3, VSIFlagE out 2, SrcBiE out 4, ImmE out N  lane ALU controls.
REQ-017 Ports IssueE out 1, ChunkE out 3, LaneMaskE out LANES  issue valid, chunk index, active lanes.
REQ-018 Ports WriteEnW out 1, WriteChunkW out 3, WriteMaskW out LANES  registered writeback of consumed issue.
REQ-019 Ports FlagsW out 2, DoneW out 1  flags of final chunk; one-cycle completion pulse.

Function
REQ-020 Accept SHALL occur on a cycle with StartD=1, BusyS=0, legal request; op fields latched, BusyS=1 next cycle.
REQ-021 Illegal = OpVL>MAXVL, OpVSIFlag=3, or OpVSIFlag=1 with OpSrcBi>=LANES; SHALL pulse ErrS next cycle, no state change.
REQ-022 Chunk count SHALL be ceil(OpVL/LANES); chunk k issued with ChunkE=k, k=0..count-1 ascending.
REQ-023 LaneMaskE SHALL be all ones except final chunk: low (OpVL-LANES*(count-1)) bits set, low-justified.
REQ-024 FSM states IDLE, ISSUE, DRAIN: IDLE->ISSUE on accept (OpVL>0); ISSUE->DRAIN when final chunk consumed; DRAIN->IDLE unconditionally.
REQ-025 Issue consumed iff IssueE=1 and StallE=0; ChunkE advances only on consumption; stall holds all E outputs stable.
REQ-026 Without stalls, first IssueE SHALL be cycle accept+1, chunk k at accept+1+k.
REQ-027 WriteEnW/WriteChunkW/WriteMaskW SHALL be 1/ChunkE/LaneMaskE one cycle after each consumed issue, else WriteEnW=0.
REQ-028 FlagsW SHALL capture ALUFlagsE on consumption of final chunk; held until next accept.
REQ-029 DoneW SHALL pulse in DRAIN, coincident with final WriteEnW; BusyS=0 in that cycle so a new accept may coincide.
REQ-030 OpVL=0 SHALL be accepted, no IssueE, go directly to DRAIN, DoneW next cycle, WriteEnW=0.
REQ-031 StartD while BusyS=1 SHALL be ignored, no ErrS.
REQ-032 IssueE=0 outside ISSUE; control outputs SHALL be 0 in IDLE.

Reset
REQ-033 Reset SHALL force IDLE and all outputs to 0 on the next edge, including mid-operation; no DoneW, WriteEnW or ErrS for the aborted op.
REQ-034 Reset SHALL take priority over StartD and StallE in the same cycle.

Structure
REQ-035 Package vec_ctrl_pkg SHALL hold LANES, MAXVL, state enum (IDLE/ISSUE/DRAIN) and VSI encodings (VSI_VEC=0, VSI_SCL=1, VSI_IMM=2).
REQ-036 Sub-module lane_mask_gen SHALL be combinational: remaining element count -> LANES-bit low-justified mask.
REQ-037 All state SHALL be in a single always_ff on clk; no latches.

Verification
REQ-038 OpVL=13, OpVSIFlag=0, no stall -> IssueE chunks 0,1,2 at accept+1..+3, masks 111111,111111,000001; DoneW at accept+4.
REQ-039 OpVL=12, StallE high at accept+2 for 2 cycles -> chunk 1 held 3 cycles, one WriteEnW per chunk, DoneW at accept+5.
REQ-040 OpVSIFlag=1, OpSrcBi=6 -> ErrS at accept+1, BusyS stays 0; OpSrcBi=5 -> accepted, SrcBiE=5.
REQ-041 OpVL=0 -> DoneW at accept+1, no IssueE/WriteEnW; OpVL=49 -> ErrS.
REQ-042 OpVL=48, reset at chunk 3 -> all outputs 0 next cycle, no DoneW; new OpVL=6 op completes normally.
REQ-043 Back-to-back: StartD held with OpVL=6 -> second accept on first DoneW cycle, second DoneW 2 cycles later.
